multi_digit_seg: RTL and testbench

Parametrised N-digit multiplexed seven-segment driver; replaces the fixed four-digit combinational-divide display. Binary values are converted to BCD by a sequential shift-add-3 engine started by a `load` strobe. Digits are scanned one per slot with an anti-ghosting blank interval, per-digit decimal points and overflow indication. Sits between the game score/timer logic and the board display pins.

---
 rtl/multi_digit_seg_if.sv | 25 ++
 rtl/multi_digit_seg.sv | 241 ++++++++++++++++++++++++
 tb/tb_multi_digit_seg.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/multi_digit_seg_if.sv
// Bus between the score/timer logic and the multiplexed seven-segment driver:
// value/load/dp_mask in, busy/overflow/segment pins out.
interface multi_digit_seg_if #(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 16
);
    logic [VALUE_W-1:0]    i_value;
    logic                  i_load;
    logic [NUM_DIGITS-1:0] i_dp_mask;
    logic                  o_busy;
    logic                  o_overflow;
    logic [6:0]            o_seg;
    logic                  o_dp;
    logic [NUM_DIGITS-1:0] o_digit_en;

    modport master (
        output i_value, i_load, i_dp_mask,
        input  o_busy, o_overflow, o_seg, o_dp, o_digit_en
    );

    modport slave (
        input  i_value, i_load, i_dp_mask,
        output o_busy, o_overflow, o_seg, o_dp, o_digit_en
    );
endinterface

// File: rtl/multi_digit_seg.sv
// N-digit multiplexed seven-segment driver with sequential shift-add-3 BCD conversion.
// Optional macro SEG_LZ_BLANK_EN enables leading-zero blanking.
`ifndef CLK_FREQ
`define CLK_FREQ 50000000
`endif

module multi_digit_seg #(
    parameter int NUM_DIGITS   = 4,
    parameter int VALUE_W      = 16,
    parameter int CLK_HZ       = `CLK_FREQ,
    parameter int REFRESH_HZ   = 100,
    parameter int BLANK_CYCLES = 2
) (
    input logic              clk,
    input logic              rst_n,
    multi_digit_seg_if.slave bus
);

    localparam int SCAN_MAX = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int SCAN_W   = (SCAN_MAX > 1) ? $clog2(SCAN_MAX) : 1;
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BCD_W    = 4 * NUM_DIGITS;
    localparam int CNT_W    = $clog2(VALUE_W + 1);

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int k = 0; k < n; k++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

    localparam logic [31:0] DISP_MAX = pow10(NUM_DIGITS) - 32'd1;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Add-3 correction applied to every nibble before each shift
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] r;
        logic [3:0]       nib;
        r = acc;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib = acc[4*k +: 4];
            if (nib >= 4'd5) begin
                r[4*k +: 4] = nib + 4'd3;
            end else begin
                r[4*k +: 4] = nib;
            end
        end
        return r;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    logic [VALUE_W-1:0]   r_shift;
    logic [BCD_W-1:0]     r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ovf_pend;
    logic [BCD_W-1:0]     r_display;
    logic                 r_overflow;
    logic                 r_busy;
    logic [SCAN_W-1:0]    r_scan_cnt;
    logic [IDX_W-1:0]     r_digit_idx;
    logic [6:0]           r_seg;
    logic                 r_dp;
    logic [NUM_DIGITS-1:0] r_digit_en;

    state_t               w_state_nxt;
    logic [VALUE_W-1:0]   w_shift_nxt;
    logic [BCD_W-1:0]     w_acc_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_ovf_pend_nxt;
    logic [BCD_W-1:0]     w_display_nxt;
    logic                 w_overflow_nxt;
    logic [BCD_W-1:0]     w_acc_adj;
    logic [31:0]          w_value_ext;

    assign w_acc_adj   = bcd_adjust(r_acc);
    assign w_value_ext = 32'(bus.i_value);

    // Converter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_display  <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ovf_pend <= w_ovf_pend_nxt;
            r_display  <= w_display_nxt;
            r_overflow <= w_overflow_nxt;
            r_busy     <= (w_state_nxt == ST_SHIFT);
        end
    end

    // Converter next state; the display only changes on the commit edge so slots never see partial BCD
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_acc_nxt      = r_acc;
        w_cnt_nxt      = r_cnt;
        w_ovf_pend_nxt = r_ovf_pend;
        w_display_nxt  = r_display;
        w_overflow_nxt = r_overflow;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_load) begin
                    w_shift_nxt    = bus.i_value;
                    w_acc_nxt      = '0;
                    w_cnt_nxt      = '0;
                    w_ovf_pend_nxt = (w_value_ext > DISP_MAX);
                    w_state_nxt    = ST_SHIFT;
                end else begin
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_W'(VALUE_W)) begin
                    w_display_nxt  = r_acc;
                    w_overflow_nxt = r_ovf_pend;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_acc_nxt      = {w_acc_adj[BCD_W-2:0], r_shift[VALUE_W-1]};
                    w_shift_nxt    = r_shift << 1;
                    w_cnt_nxt      = r_cnt + CNT_W'(1);
                    w_state_nxt    = ST_SHIFT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Slot timer and digit pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= '0;
        end else begin
            if (r_scan_cnt == SCAN_W'(SCAN_MAX - 1)) begin
                r_scan_cnt <= '0;
                if (r_digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                    r_digit_idx <= '0;
                end else begin
                    r_digit_idx <= r_digit_idx + IDX_W'(1);
                end
            end else begin
                r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
            end
        end
    end

    logic [BCD_W-1:0]      w_disp_sh;
    logic [NUM_DIGITS-1:0] w_dp_sh;
    logic                  w_lz_blank;
    logic [6:0]            w_seg_nxt;
    logic                  w_dp_nxt;
    logic [NUM_DIGITS-1:0] w_en_nxt;

    assign w_disp_sh = r_display >> {r_digit_idx, 2'b00};
    assign w_dp_sh   = bus.i_dp_mask >> r_digit_idx;

`ifdef SEG_LZ_BLANK_EN
    // Selected nibble and everything above it zero means this is a leading zero
    assign w_lz_blank = (r_digit_idx != IDX_W'(0)) && (w_disp_sh == '0);
`else
    assign w_lz_blank = 1'b0;
`endif

    // Pin values for the current slot
    always_comb begin
        w_seg_nxt = 7'b0000000;
        w_dp_nxt  = 1'b0;
        w_en_nxt  = '0;
        if (r_scan_cnt < SCAN_W'(BLANK_CYCLES)) begin
            w_seg_nxt = 7'b0000000;
            w_dp_nxt  = 1'b0;
            w_en_nxt  = '0;
        end else begin
            w_en_nxt = NUM_DIGITS'(1) << r_digit_idx;
            w_dp_nxt = w_dp_sh[0];
            if (r_overflow) begin
                w_seg_nxt = 7'b0000001;
            end else if (w_lz_blank) begin
                w_seg_nxt = 7'b0000000;
            end else begin
                w_seg_nxt = seg_decode(w_disp_sh[3:0]);
            end
        end
    end

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg      <= 7'b0000000;
            r_dp       <= 1'b0;
            r_digit_en <= '0;
        end else begin
            r_seg      <= w_seg_nxt;
            r_dp       <= w_dp_nxt;
            r_digit_en <= w_en_nxt;
        end
    end

    assign bus.o_busy     = r_busy;
    assign bus.o_overflow = r_overflow;
    assign bus.o_seg      = r_seg;
    assign bus.o_dp       = r_dp;
    assign bus.o_digit_en = r_digit_en;

endmodule

// File: tb/tb_multi_digit_seg.sv
// Self-checking bench for multi_digit_seg: decimal-arithmetic model checked every cycle plus directed scenarios.
module tb_multi_digit_seg;
    localparam int N     = 4;
    localparam int VW    = 16;
    localparam int BL    = 2;
    localparam int SCAN  = 10;
`ifdef SEG_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif
    localparam logic [6:0] ZS = LZ ? 7'b0000000 : 7'b1111110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_digit_seg_if #(.NUM_DIGITS(N), .VALUE_W(VW)) bus ();

    multi_digit_seg #(
        .NUM_DIGITS(N), .VALUE_W(VW), .CLK_HZ(4000), .REFRESH_HZ(100), .BLANK_CYCLES(BL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [6:0] dec [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    function automatic int p10(input int n);
        int r;
        r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    // Model: display as a decimal integer, scan position as a cycle count since reset
    int m_cyc, m_disp, m_pend, m_left;
    bit m_busy, m_ovf;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_disp = 0; m_pend = 0; m_left = 0;
            m_busy = 1'b0; m_ovf = 1'b0;
            e_seg = 7'd0; e_dp = 1'b0; e_en = 4'd0;
        end else begin
            int sc, idx;
            sc  = m_cyc % SCAN;
            idx = (m_cyc / SCAN) % N;
            if (sc < BL) begin
                e_seg = 7'd0; e_dp = 1'b0; e_en = 4'd0;
            end else begin
                e_en = 4'(1 << idx);
                e_dp = bus.i_dp_mask[idx];
                if (m_ovf) e_seg = 7'b0000001;
                else if (LZ && idx > 0 && m_disp < p10(idx)) e_seg = 7'd0;
                else e_seg = dec[(m_disp / p10(idx)) % 10];
            end
            m_cyc++;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_ovf  = (m_pend > p10(N) - 1);
                    m_disp = m_pend % p10(N);
                    m_busy = 1'b0;
                end
            end else if (bus.i_load) begin
                m_pend = int'(bus.i_value);
                m_left = VW + 1;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("seg", {25'd0, bus.o_seg}, {25'd0, e_seg});
        check("dp", {31'd0, bus.o_dp}, {31'd0, e_dp});
        check("digit_en", {28'd0, bus.o_digit_en}, {28'd0, e_en});
        check("busy", {31'd0, bus.o_busy}, {31'd0, m_busy});
        check("overflow", {31'd0, bus.o_overflow}, {31'd0, m_ovf});
    end

    logic [6:0] cap_seg [0:3];
    logic [3:0] cap_dp;
    int en0_cnt, blank_cnt;

    task automatic do_load(input int v);
        @(negedge clk);
        bus.i_value = VW'(v);
        bus.i_load  = 1'b1;
        @(negedge clk);
        bus.i_load  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.o_busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("busy_done", {31'd0, bus.o_busy}, 32'd0);
        @(negedge clk);
    endtask

    // Four full slot periods: last sample per digit, enable rotation and cadence counts
    task automatic capture();
        logic [3:0] last;
        last = 4'd0; en0_cnt = 0; blank_cnt = 0;
        for (int c = 0; c < 4 * SCAN; c++) begin
            @(negedge clk);
            case (bus.o_digit_en)
                4'b0001: begin cap_seg[0] = bus.o_seg; cap_dp[0] = bus.o_dp; en0_cnt++; end
                4'b0010: begin cap_seg[1] = bus.o_seg; cap_dp[1] = bus.o_dp; end
                4'b0100: begin cap_seg[2] = bus.o_seg; cap_dp[2] = bus.o_dp; end
                4'b1000: begin cap_seg[3] = bus.o_seg; cap_dp[3] = bus.o_dp; end
                4'b0000: begin blank_cnt++; check("blank_seg", {25'd0, bus.o_seg}, 32'd0); end
                default: check("en_onehot", {28'd0, bus.o_digit_en}, 32'd1);
            endcase
            if (last != 4'd0 && bus.o_digit_en != 4'd0 && bus.o_digit_en != last)
                check("en_order", {28'd0, bus.o_digit_en}, {28'd0, last[2:0], last[3]});
            if (bus.o_digit_en != 4'd0) last = bus.o_digit_en;
        end
    endtask

    task automatic check_digits(input string name, input logic [6:0] d3, input logic [6:0] d2,
                                input logic [6:0] d1, input logic [6:0] d0);
        check({name, "_d0"}, {25'd0, cap_seg[0]}, {25'd0, d0});
        check({name, "_d1"}, {25'd0, cap_seg[1]}, {25'd0, d1});
        check({name, "_d2"}, {25'd0, cap_seg[2]}, {25'd0, d2});
        check({name, "_d3"}, {25'd0, cap_seg[3]}, {25'd0, d3});
    endtask

    initial begin
        int n;
        bus.i_load = 1'b0; bus.i_value = '0; bus.i_dp_mask = 4'b0000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_seg", {25'd0, bus.o_seg}, 32'd0);
        check("rst_en", {28'd0, bus.o_digit_en}, 32'd0);
        check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_load(1234);
        n = 0;
        while (bus.o_busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
        check("busy_len", n, 32'd17);
        @(negedge clk);
        capture();
        check_digits("v1234", 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011);
        check("en0_cycles", en0_cnt, 32'd8);
        check("blank_cycles", blank_cnt, 32'd8);

        do_load(12345);
        wait_idle();
        check("ovf_set", {31'd0, bus.o_overflow}, 32'd1);
        capture();
        check_digits("ovf", 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001);

        do_load(9999);
        wait_idle();
        check("ovf_clr", {31'd0, bus.o_overflow}, 32'd0);
        capture();
        check_digits("v9999", 7'b1111011, 7'b1111011, 7'b1111011, 7'b1111011);

        do_load(42);
        do_load(7777);
        wait_idle();
        capture();
        check_digits("drop", ZS, ZS, 7'b0110011, 7'b1101101);

        bus.i_dp_mask = 4'b0100;
        do_load(5);
        wait_idle();
        capture();
        check_digits("v5", ZS, ZS, ZS, 7'b1011011);
        check("v5_dp", {28'd0, cap_dp}, 32'h4);

        bus.i_dp_mask = 4'b0000;
        do_load(300);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_seg", {25'd0, bus.o_seg}, 32'd0);
        check("arst_en", {28'd0, bus.o_digit_en}, 32'd0);
        check("arst_busy", {31'd0, bus.o_busy}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_idle", {31'd0, bus.o_busy}, 32'd0);
        capture();
        check_digits("arst", ZS, ZS, ZS, 7'b1111110);
        check("arst_ovf", {31'd0, bus.o_overflow}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
